// File: rtl/aes128_key_sched_seq_if.sv
// Key-in / round-key-out bundle for aes128_key_sched_seq.
// master = key source and round-key consumer, slave = the key scheduler.
interface aes128_key_sched_seq_if;
    localparam int unsigned KEY_W = 128;
    localparam int unsigned RND_W = 4;

    logic              key_valid;
    logic [KEY_W-1:0]  key_in;
    logic              key_ready;
    logic              busy;
    logic              done;
    logic              rk_valid;
    logic [RND_W-1:0]  rk_round;
    logic [KEY_W-1:0]  rk_out;
    logic [RND_W-1:0]  rk_rd_idx;
    logic [KEY_W-1:0]  rk_rd_data;

    modport master (
        output key_valid, key_in, rk_rd_idx,
        input  key_ready, busy, done, rk_valid, rk_round, rk_out, rk_rd_data
    );

    modport slave (
        input  key_valid, key_in, rk_rd_idx,
        output key_ready, busy, done, rk_valid, rk_round, rk_out, rk_rd_data
    );
endinterface

// File: rtl/aes128_key_sched_seq.sv
// Iterative AES-128 key expansion sharing one byte-wide S-box (4 SUB + 1 MIX cycles per round).
// Optional round-key bank with registered readback when KEYSCHED_STORE_EN is defined.
module aes128_key_sched_seq (
    input  logic                    clk,
    input  logic                    rst,
    aes128_key_sched_seq_if.slave   ks
);
    localparam int unsigned KEY_W    = 128;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned RND_W    = 4;
    localparam int unsigned NUM_RK   = 11;
    localparam logic [RND_W-1:0] LAST_RND = 4'd10;

    typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} state_t;

    // FIPS-197 S-box; element 255 holds S(0x00), so S(x) = SBOX[~x]
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t              state_q;
    logic [KEY_W-1:0]    key_q;
    logic [3:0][7:0]     temp_q;
    logic [RND_W-1:0]    round_q;
    logic [1:0]          cnt_q;
    logic [7:0]          rcon_q;
    logic                ready_q;
    logic                busy_q;
    logic                done_q;
    logic                rk_valid_q;
    logic [RND_W-1:0]    rk_round_q;
    logic [KEY_W-1:0]    rk_out_q;

    logic                accept;
    logic [7:0]          sub_in;
    logic [7:0]          sub_out;
    logic [WORD_W-1:0]   w0_d, w1_d, w2_d, w3_d;
    logic [KEY_W-1:0]    key_d;
    logic [7:0]          rcon_d;

    assign accept = ks.key_valid && ready_q;

    // RotWord byte select feeding the shared S-box
    always_comb begin
        sub_in = key_q[23:16];
        unique case (cnt_q)
            2'd0: sub_in = key_q[23:16];
            2'd1: sub_in = key_q[15:8];
            2'd2: sub_in = key_q[7:0];
            2'd3: sub_in = key_q[31:24];
            default: sub_in = key_q[23:16];
        endcase
        sub_out = SBOX[~sub_in];
    end

    always_comb begin
        w0_d   = key_q[127:96] ^ temp_q ^ {rcon_q, 24'h0};
        w1_d   = key_q[95:64]  ^ w0_d;
        w2_d   = key_q[63:32]  ^ w1_d;
        w3_d   = key_q[31:0]   ^ w2_d;
        key_d  = {w0_d, w1_d, w2_d, w3_d};
        rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            key_q      <= '0;
            temp_q     <= '0;
            round_q    <= '0;
            cnt_q      <= '0;
            rcon_q     <= 8'h01;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_round_q <= '0;
            rk_out_q   <= '0;
        end else begin
            rk_valid_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        key_q      <= ks.key_in;
                        round_q    <= 4'd1;
                        cnt_q      <= 2'd0;
                        rcon_q     <= 8'h01;
                        rk_valid_q <= 1'b1;
                        rk_round_q <= '0;
                        rk_out_q   <= ks.key_in;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        state_q    <= SUB;
                    end
                end
                SUB: begin
                    // byte counter 0..3 lands in temp[31:24] down to temp[7:0]
                    temp_q[~cnt_q] <= sub_out;
                    cnt_q          <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_q <= MIX;
                    end
                end
                MIX: begin
                    key_q      <= key_d;
                    rk_valid_q <= 1'b1;
                    rk_round_q <= round_q;
                    rk_out_q   <= key_d;
                    rcon_q     <= rcon_d;
                    if (round_q == LAST_RND) begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        round_q <= round_q + 4'd1;
                        state_q <= SUB;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ks.key_ready = ready_q;
    assign ks.busy      = busy_q;
    assign ks.done      = done_q;
    assign ks.rk_valid  = rk_valid_q;
    assign ks.rk_round  = rk_round_q;
    assign ks.rk_out    = rk_out_q;

`ifdef KEYSCHED_STORE_EN
    logic [KEY_W-1:0] bank_q [NUM_RK];
    logic [KEY_W-1:0] rd_data_q;

    // Bank follows the emitted stream; unwritten entries keep older contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_RK; i++) begin
                bank_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (rk_valid_q && (rk_round_q < RND_W'(NUM_RK))) begin
                bank_q[rk_round_q] <= rk_out_q;
            end
            if (ks.rk_rd_idx < RND_W'(NUM_RK)) begin
                rd_data_q <= bank_q[ks.rk_rd_idx];
            end else begin
                rd_data_q <= '0;
            end
        end
    end

    assign ks.rk_rd_data = rd_data_q;
`else
    assign ks.rk_rd_data = '0;
`endif
endmodule

// File: tb/tb_aes128_key_sched_seq.sv
// Directed bench for aes128_key_sched_seq: FIPS-197 A.1 and all-zero keys, busy-ignore, reset abort,
// and the round-key bank (KEYSCHED_STORE_EN) or its absence.
module tb_aes128_key_sched_seq;
    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_Z  = 128'h0;
    localparam logic [127:0] Z_R1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    aes128_key_sched_seq_if ifc ();

    aes128_key_sched_seq dut (
        .clk (clk),
        .rst (rst),
        .ks  (ifc.slave)
    );

    task automatic test_reset();
        ifc.key_valid = 1'b0;
        ifc.key_in    = '0;
        ifc.rk_rd_idx = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (ifc.key_ready !== 1'b1 || ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.rk_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl got ready=%b busy=%b done=%b vld=%b want 1 0 0 0",
                     ifc.key_ready, ifc.busy, ifc.done, ifc.rk_valid);
        end
        total++;
        if (ifc.rk_round !== 4'd0 || ifc.rk_out !== 128'h0 || ifc.rk_rd_data !== 128'h0) begin
            bad++;
            $display("FAIL reset_data got round=%0d out=%h rd=%h want zeros", ifc.rk_round, ifc.rk_out, ifc.rk_rd_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Accept one key and track the full 51-cycle expansion
    task automatic run_expansion(input logic [127:0] key, input logic [127:0] r1,
                                 input logic [127:0] r10, input string nm);
        int vcnt = 0;
        int verr = 0;
        int rderr = 0;
        @(negedge clk);
        total++;
        if (ifc.key_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s pre_ready got=%b want=1", nm, ifc.key_ready);
        end
        ifc.key_in    = key;
        ifc.key_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 53; k++) begin
            @(negedge clk);
            if (k == 1) ifc.key_valid = 1'b0;
            if (ifc.rk_valid === 1'b1) begin
                vcnt++;
                if ((k % 5) != 1 || ifc.rk_round !== 4'((k - 1) / 5)) verr++;
            end else if ((k % 5) == 1 && k <= 51) begin
                verr++;
            end
`ifndef KEYSCHED_STORE_EN
            if (ifc.rk_rd_data !== 128'h0) rderr++;
            ifc.rk_rd_idx = 4'(k);
`endif
            if (k == 1) begin
                total++;
                if (ifc.rk_out !== key || ifc.busy !== 1'b1 || ifc.key_ready !== 1'b0 || ifc.done !== 1'b0) begin
                    bad++;
                    $display("FAIL %s round0 got out=%h busy=%b ready=%b done=%b want out=%h 1 0 0",
                             nm, ifc.rk_out, ifc.busy, ifc.key_ready, ifc.done, key);
                end
            end
            if (k == 6) begin
                total++;
                if (ifc.rk_out !== r1) begin
                    bad++;
                    $display("FAIL %s round1 got=%h want=%h", nm, ifc.rk_out, r1);
                end
            end
            if (k == 51) begin
                total++;
                if (ifc.rk_out !== r10 || ifc.done !== 1'b1 || ifc.key_ready !== 1'b1 || ifc.busy !== 1'b0) begin
                    bad++;
                    $display("FAIL %s round10 got out=%h done=%b ready=%b busy=%b want out=%h 1 1 0",
                             nm, ifc.rk_out, ifc.done, ifc.key_ready, ifc.busy, r10);
                end
            end
        end
        total++;
        if (vcnt != 11 || verr != 0) begin
            bad++;
            $display("FAIL %s valid_pattern got count=%0d errors=%0d want 11 0", nm, vcnt, verr);
        end
`ifndef KEYSCHED_STORE_EN
        total++;
        if (rderr != 0) begin
            bad++;
            $display("FAIL %s rd_data_tied got nonzero_cycles=%0d want 0", nm, rderr);
        end
`endif
    endtask

    task automatic test_fips_a1();
        run_expansion(KEY_A1, A1_R1, A1_R10, "fips_a1");
    endtask

    task automatic test_zero_key();
        run_expansion(KEY_Z, Z_R1, Z_R10, "zero_key");
    endtask

    task automatic test_store();
`ifdef KEYSCHED_STORE_EN
        logic [3:0]   idx [4]  = '{4'd1, 4'd10, 4'd12, 4'd0};
        logic [127:0] want [4] = '{A1_R1, A1_R10, 128'h0, KEY_A1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ifc.rk_rd_idx = idx[i];
            @(negedge clk);
            total++;
            if (ifc.rk_rd_data !== want[i]) begin
                bad++;
                $display("FAIL store_read idx=%0d got=%h want=%h", idx[i], ifc.rk_rd_data, want[i]);
            end
        end
`else
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ifc.rk_rd_idx = 4'(i);
            @(negedge clk);
            total++;
            if (ifc.rk_rd_data !== 128'h0) begin
                bad++;
                $display("FAIL nostore_read idx=%0d got=%h want=0", i, ifc.rk_rd_data);
            end
        end
`endif
    endtask

    // Second key held on key_valid throughout; only taken once DONE is reached
    task automatic test_busy_ignore();
        bit seen_done = 1'b0;
        @(negedge clk);
        ifc.key_in    = KEY_A1;
        ifc.key_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 52; k++) begin
            @(negedge clk);
            ifc.key_in = KEY_Z;
            if (k == 1) begin
                total++;
                if (ifc.rk_out !== KEY_A1) begin
                    bad++;
                    $display("FAIL busy_round0 got=%h want=%h", ifc.rk_out, KEY_A1);
                end
            end
            if (k == 6) begin
                total++;
                if (ifc.rk_out !== A1_R1) begin
                    bad++;
                    $display("FAIL busy_round1 got=%h want=%h", ifc.rk_out, A1_R1);
                end
            end
            if (k == 51) begin
                total++;
                if (ifc.rk_out !== A1_R10 || ifc.done !== 1'b1) begin
                    bad++;
                    $display("FAIL busy_round10 got out=%h done=%b want out=%h done=1", ifc.rk_out, ifc.done, A1_R10);
                end
            end
            if (k == 52) begin
                total++;
                if (ifc.rk_valid !== 1'b1 || ifc.rk_round !== 4'd0 || ifc.rk_out !== KEY_Z || ifc.done !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_reaccept got vld=%b round=%0d out=%h done=%b want 1 0 %h 0",
                             ifc.rk_valid, ifc.rk_round, ifc.rk_out, ifc.done, KEY_Z);
                end
            end
        end
        ifc.key_valid = 1'b0;
        for (int k = 0; k < 60 && !seen_done; k++) begin
            @(negedge clk);
            if (ifc.done === 1'b1) seen_done = 1'b1;
        end
        total++;
        if (!seen_done || ifc.rk_out !== Z_R10) begin
            bad++;
            $display("FAIL busy_second_done got done=%b out=%h want done=1 out=%h", seen_done, ifc.rk_out, Z_R10);
        end
    endtask

    task automatic test_reset_abort();
        int late_vld = 0;
        @(negedge clk);
        ifc.key_in    = KEY_A1;
        ifc.key_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            ifc.key_valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        total++;
        if (ifc.key_ready !== 1'b1 || ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.rk_valid !== 1'b0 ||
            ifc.rk_round !== 4'd0 || ifc.rk_out !== 128'h0 || ifc.rk_rd_data !== 128'h0) begin
            bad++;
            $display("FAIL abort_outputs got ready=%b busy=%b done=%b vld=%b round=%0d out=%h rd=%h want 1 0 0 0 0 0 0",
                     ifc.key_ready, ifc.busy, ifc.done, ifc.rk_valid, ifc.rk_round, ifc.rk_out, ifc.rk_rd_data);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (ifc.rk_valid !== 1'b0 || ifc.busy !== 1'b0) late_vld++;
        end
        total++;
        if (late_vld != 0) begin
            bad++;
            $display("FAIL abort_quiet got active_cycles=%0d want 0", late_vld);
        end
        run_expansion(KEY_A1, A1_R1, A1_R10, "after_abort");
    endtask

    initial begin
        test_reset();
        test_fips_a1();
        test_store();
        test_zero_key();
        test_busy_ignore();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
